// File: rtl/screen_sequencer.sv
// Top-level display-mode sequencer: START / GAME / WAIT screen selects, switched only on
// frame boundaries so the compositor never changes screens mid-frame.
module screen_sequencer #(
    parameter int H_LAST      = 799,
    parameter int V_LAST      = 524,
    parameter int WAIT_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       start_btn,
    input  logic       game_over,
    input  logic [2:0] player_count,
    output logic       start_state,
    output logic       game_state,
    output logic       wait_state,
    output logic       frame_tick,
    output logic [7:0] wait_frames
);

    // One-hot encoding: the state register bits are the screen-select outputs themselves.
    typedef enum logic [2:0] {
        ST_START = 3'b001,
        ST_GAME  = 3'b010,
        ST_WAIT  = 3'b100
    } state_t;

    localparam logic [9:0] H_END    = 10'(H_LAST);
    localparam logic [9:0] V_END    = 10'(V_LAST);
    localparam logic [7:0] WAIT_END = 8'(WAIT_FRAMES);

    state_t     state_q, state_d;
    logic       tick_q, tick_d;
    logic       sync1_q, sync2_q, btn_prev_q;
    logic       start_req_q, start_req_d;
    logic       go_req_q, go_req_d;
    logic [7:0] wf_q, wf_d;
    logic [7:0] wf_inc;
    logic       btn_rise;

    always_comb begin
        tick_d      = (DrawX == H_END) && (DrawY == V_END);
        btn_rise    = sync2_q & ~btn_prev_q;
        wf_inc      = (wf_q == 8'hFF) ? wf_q : wf_q + 8'd1;
        state_d     = state_q;
        start_req_d = start_req_q;
        go_req_d    = go_req_q;
        wf_d        = wf_q;

        // A request landing on its own servicing edge is dropped: the clear wins.
        case (state_q)
            ST_START: begin
                if (btn_rise) start_req_d = 1'b1;
                if (tick_q && start_req_q) begin
                    state_d     = ST_GAME;
                    start_req_d = 1'b0;
                end
            end
            ST_GAME: begin
                if (game_over) go_req_d = 1'b1;
                if (tick_q && go_req_q) begin
                    state_d  = ST_WAIT;
                    go_req_d = 1'b0;
                    wf_d     = 8'd0;
                end
            end
            ST_WAIT: begin
                if (tick_q) begin
                    wf_d = wf_inc;
                    if (wf_inc == WAIT_END) begin
                        wf_d    = 8'd0;
                        state_d = (player_count >= 3'd2) ? ST_GAME : ST_START;
                    end
                end
            end
            default: begin
                state_d     = ST_START;
                start_req_d = 1'b0;
                go_req_d    = 1'b0;
                wf_d        = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_START;
            tick_q      <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            btn_prev_q  <= 1'b0;
            start_req_q <= 1'b0;
            go_req_q    <= 1'b0;
            wf_q        <= 8'd0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            sync1_q     <= start_btn;
            sync2_q     <= sync1_q;
            btn_prev_q  <= sync2_q;
            start_req_q <= start_req_d;
            go_req_q    <= go_req_d;
            wf_q        <= wf_d;
        end
    end

    assign start_state = state_q[0];
    assign game_state  = state_q[1];
    assign wait_state  = state_q[2];
    assign frame_tick  = tick_q;
    assign wait_frames = wf_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: an event-level model of screen changes per frame boundary
// feeds an expected queue that a monitor drains on every frame_tick.
module tb_screen_sequencer;

    localparam int H_LAST      = 15;
    localparam int V_LAST      = 7;
    localparam int WAIT_FRAMES = 3;
    localparam int FRAME_CYC   = (H_LAST + 1) * (V_LAST + 1);
    localparam int M_START = 0, M_GAME = 1, M_WAIT = 2;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] DrawX = '0, DrawY = '0;
    logic       start_btn = 1'b0, game_over = 1'b0;
    logic [2:0] player_count = 3'd0;
    logic       start_state, game_state, wait_state, frame_tick;
    logic [7:0] wait_frames;

    always #5 clk = ~clk;

    screen_sequencer #(.H_LAST(H_LAST), .V_LAST(V_LAST), .WAIT_FRAMES(WAIT_FRAMES)) dut (
        .clk(clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
        .start_btn(start_btn), .game_over(game_over), .player_count(player_count),
        .start_state(start_state), .game_state(game_state), .wait_state(wait_state),
        .frame_tick(frame_tick), .wait_frames(wait_frames)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [10:0] exp_q[$];     // {wait,game,start, wait_frames}
    int          start_judge_q[$];
    int          m_st = M_START, m_wf = 0, cyc = 0;
    bit          m_start_req = 0, m_go_req = 0, m_tick = 0, btn_prev = 0;
    bit          d_btn = 0, d_go = 0;
    logic [2:0]  d_pc = 3'd2;

    function automatic logic [2:0] sel(input int s);
        return 3'b001 << s;
    endfunction

    task automatic model_reset();
        m_st = M_START; m_wf = 0; m_start_req = 0; m_go_req = 0; m_tick = 0; btn_prev = 0;
        start_judge_q.delete();
    endtask

    // One clock cycle: advance the raster, drive inputs, and apply the screen rules.
    task automatic step(input bit rst_on, input bit rnd);
        bit tick_now, set_start, set_go, moved;
        @(posedge clk); #1;
        cyc++;
        tick_now = m_tick;
        if (DrawX == 10'(H_LAST)) begin
            DrawX = '0;
            DrawY = (DrawY == 10'(V_LAST)) ? '0 : DrawY + 10'd1;
        end else DrawX = DrawX + 10'd1;
        reset = rst_on;
        if (rst_on) begin
            start_btn = 0; game_over = 0;
            model_reset();
            return;
        end
        if (rnd) begin
            game_over = ($urandom_range(0, 99) == 0) || (tick_now && $urandom_range(0, 3) == 0);
            if (!start_btn) start_btn = ($urandom_range(0, 149) == 0);
            else            start_btn = ($urandom_range(0, 299) != 0);
            player_count = 3'($urandom_range(0, 7));
        end else begin
            game_over = d_go; d_go = 0;
            start_btn = d_btn;
            player_count = d_pc;
        end
        // A button rise is seen by the sequencer two cycles later (synchronizer delay).
        if (start_btn && !btn_prev) start_judge_q.push_back(cyc + 2);
        btn_prev = start_btn;
        set_start = 0;
        if (start_judge_q.size() > 0 && start_judge_q[0] == cyc) begin
            void'(start_judge_q.pop_front());
            set_start = (m_st == M_START);
        end
        set_go = game_over && (m_st == M_GAME);
        moved = 0;
        if (tick_now) begin
            if (m_st == M_START && m_start_req) begin
                m_st = M_GAME; m_start_req = 0; moved = 1;
            end else if (m_st == M_GAME && m_go_req) begin
                m_st = M_WAIT; m_go_req = 0; m_wf = 0; moved = 1;
            end else if (m_st == M_WAIT) begin
                m_wf = (m_wf + 1 > 255) ? 255 : m_wf + 1;
                if (m_wf == WAIT_FRAMES) begin
                    m_wf = 0; moved = 1;
                    m_st = (player_count >= 3'd2) ? M_GAME : M_START;
                end
            end
            exp_q.push_back({sel(m_st), 8'(m_wf)});
        end
        if (!moved) begin
            if (set_start) m_start_req = 1;
            if (set_go)    m_go_req = 1;
        end
        m_tick = (DrawX == 10'(H_LAST)) && (DrawY == 10'(V_LAST));
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit          mon_en = 0, mon_fresh = 1;
    logic        ft_prev = 0, px_last_prev = 0;
    logic [2:0]  st_prev = 3'b001, st_now;
    logic [7:0]  wf_prev = 0;
    logic [10:0] e;

    always @(negedge clk) begin
        if (mon_en) begin
            st_now = {wait_state, game_state, start_state};
            check("onehot", $countones(st_now), 1);
            if (!mon_fresh) begin
                check("frame_tick", frame_tick, px_last_prev);
                if (ft_prev) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL sb_empty: got boundary with no expected entry at %0t", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("state", st_now, e[10:8]);
                        check("wait_frames", wait_frames, e[7:0]);
                    end
                end else begin
                    check("hold", {st_now, wait_frames}, {st_prev, wf_prev});
                end
            end
            mon_fresh    = 0;
            ft_prev      = frame_tick;
            st_prev      = st_now;
            wf_prev      = wait_frames;
            px_last_prev = (DrawX == 10'(H_LAST)) && (DrawY == 10'(V_LAST));
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_start"}, start_state, 1);
        check({tag, "_game"},  game_state,  0);
        check({tag, "_wait"},  wait_state,  0);
        check({tag, "_tick"},  frame_tick,  0);
        check({tag, "_wf"},    wait_frames, 0);
    endtask

    task automatic do_reset(input bit async_part);
        d_btn = 0; d_go = 0;
        if (async_part) begin
            @(negedge clk); #2;
            reset = 1; mon_en = 0; exp_q.delete();
            #1 check_reset_values("async_rst");
            model_reset();
        end else begin
            mon_en = 0; exp_q.delete();
        end
        repeat (3) step(1, 0);
        step(0, 0);
        mon_en = 1; mon_fresh = 1;
        @(negedge clk);
        check_reset_values("post_rst");
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) step(0, rnd);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int guard;
        do_reset(0);

        // Press mid-frame and hold across several frames: one move to GAME only.
        guard = 0;
        while (DrawY != 10'd3 && guard < 4 * FRAME_CYC) begin step(0, 0); guard++; end
        d_btn = 1;
        run(3 * FRAME_CYC, 0);
        d_btn = 0;
        run(8, 0);

        // Game over with two players: WAIT, then back to GAME.
        d_pc = 3'd2; d_go = 1;
        run(6 * FRAME_CYC, 0);

        // Game over on the frame_tick cycle with one player: WAIT one frame late, then START.
        guard = 0;
        while (!m_tick && guard < 2 * FRAME_CYC) begin step(0, 0); guard++; end
        check("tick_found", m_tick, 1);
        d_pc = 3'd1; d_go = 1;
        step(0, 0);
        run(6 * FRAME_CYC, 0);

        // Game over while in START is dropped.
        d_go = 1;
        run(2 * FRAME_CYC, 0);

        // Reset in WAIT with two frames elapsed, mid-line.
        d_pc = 3'd2; d_btn = 1;
        run(FRAME_CYC + 8, 0);
        d_btn = 0; d_go = 1;
        guard = 0;
        while (!(m_st == M_WAIT && m_wf == 2 && DrawX == 10'd5) && guard < 8 * FRAME_CYC) begin
            step(0, 0); guard++;
        end
        check("reached_wait2", (m_st == M_WAIT && m_wf == 2), 1);
        do_reset(1);

        // A latched start request must not survive reset.
        guard = 0;
        while (DrawY != 10'd1 && guard < 2 * FRAME_CYC) begin step(0, 0); guard++; end
        d_btn = 1; step(0, 0); d_btn = 0;
        run(10, 0);
        do_reset(1);
        run(3 * FRAME_CYC, 0);

        // Randomized traffic.
        run(60 * FRAME_CYC, 1);
        d_btn = 0; d_go = 0;
        run(4, 0);

        @(negedge clk);
        @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
